// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing front end for a multi-cycle 32x32 unsigned multiplier.
// Handles RV32M sign conversion, input hold time and result word selection.
`default_nettype none

module mul_ctrl #(
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [63:0] mul_answer,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        sel_hi, sel_hi_nx;
  logic        neg, neg_nx;
  logic        div, div_nx;
  logic [31:0] op1_nx, op2_nx;
  logic [31:0] data_nx;
  logic        valid_nx;

  logic        a_neg, b_neg;
  logic [63:0] prod;

  // rst_n gates req_ready so nothing is accepted while reset is held
  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);

  assign a_neg = ((funct3 == 3'b001) || (funct3 == 3'b010)) && rs1[31];
  assign b_neg = (funct3 == 3'b001) && rs2[31];
  assign prod  = neg ? (64'd0 - mul_answer) : mul_answer;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_hi_nx = sel_hi;
    neg_nx   = neg;
    div_nx   = div;
    op1_nx   = mul_op1;
    op2_nx   = mul_op2;
    data_nx  = resp_data;
    valid_nx = resp_valid;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = WAIT;
          cnt_nx   = 8'd0;
          div_nx   = funct3[2];
          // divide encodings leave the multiplier inputs untouched
          if (!funct3[2]) begin
            sel_hi_nx = |funct3[1:0];
            neg_nx    = a_neg ^ b_neg;
            op1_nx    = a_neg ? (32'd0 - rs1) : rs1;
            op2_nx    = b_neg ? (32'd0 - rs2) : rs2;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt + 8'd1;
        if (div) begin
          state_nx = DONE;
          data_nx  = 32'd0;
          valid_nx = 1'b1;
        end else if (cnt == LAST_CNT) begin
          state_nx = DONE;
          data_nx  = sel_hi ? prod[63:32] : prod[31:0];
          valid_nx = 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase

    // flush wins over a same-cycle acceptance
    if (flush) begin
      state_nx  = IDLE;
      cnt_nx    = 8'd0;
      valid_nx  = 1'b0;
      sel_hi_nx = sel_hi;
      neg_nx    = neg;
      div_nx    = div;
      op1_nx    = mul_op1;
      op2_nx    = mul_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      sel_hi     <= 1'b0;
      neg        <= 1'b0;
      div        <= 1'b0;
      mul_op1    <= 32'd0;
      mul_op2    <= 32'd0;
      resp_data  <= 32'd0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel_hi     <= sel_hi_nx;
      neg        <= neg_nx;
      div        <= div_nx;
      mul_op1    <= op1_nx;
      mul_op2    <= op2_nx;
      resp_data  <= data_nx;
      resp_valid <= valid_nx;
    end
  end

endmodule

`default_nettype wire
